// File: rtl/instruction_fetch.sv
// instruction_fetch: single-cycle-latency fetch stage with redirect, stall and decode handshake.
// Define FETCH_HALT_ON_ZERO_EN to make an all-zero instruction word halt fetch until a redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d, cnt_q, cnt_d;
  logic        ir_valid_q, ir_valid_d, misalign_q, misalign_d;
  logic        load, halt_hit, fetch;
  assign load = (state_q == RUN) && (!ir_valid_q || ir_ready) && !redirect_valid;
`ifdef FETCH_HALT_ON_ZERO_EN
  assign halt_hit = load && (imem_instr == 32'h00000000);
`else
  assign halt_hit = 1'b0;
`endif
  assign fetch = load && !halt_hit;
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = redirect_valid ? RUN : halt_hit ? HALTED : state_q;
  end
  always_comb begin
`ifdef FETCH_HALT_ON_ZERO_EN
    halted = (state_q == HALTED);
`else
    halted = 1'b0;
`endif
  end
  // Redirect wins over everything except reset and flushes the held instruction.
  always_comb begin
    pc_d       = redirect_valid ? {redirect_target[31:2], 2'b00} : fetch ? pc_q + 32'(PC_STEP) : pc_q;
    ir_d       = fetch ? imem_instr : ir_q;
    ir_pc_d    = fetch ? pc_q : ir_pc_q;
    ir_valid_d = redirect_valid ? 1'b0 : fetch ? 1'b1 : (ir_valid_q && !ir_ready);
    cnt_d      = fetch ? cnt_q + 32'd1 : cnt_q;
    misalign_d = misalign_q || (redirect_valid && (redirect_target[1:0] != 2'b00));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= 32'h0;
      ir_valid_q <= 1'b0;
      cnt_q      <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end
  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign misalign    = misalign_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, stall, redirect, halt and reset behaviour.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, ir_ready;
  logic [31:0] redirect_target, imem_addr, imem_instr, ir, ir_pc, fetch_count;
  logic        ir_valid, halted, misalign;
  int          checks = 0, failures = 0;
  logic [31:0] exp_cnt;
  always #5 clk = ~clk;
  // Word at byte 12 is zero; every other word encodes its own address.
  assign imem_instr = (imem_addr == 32'hC) ? 32'h0 : {8'hA5, imem_addr[23:0]};
  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .halted(halted), .misalign(misalign), .fetch_count(fetch_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; ir_ready = 1'b1;
    step();
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_pc", imem_addr, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_cnt", fetch_count, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    reset = 1'b0;
    step();
    check("f1_ir", ir, 32'hA5000000);
    check("f1_irpc", ir_pc, 32'h0);
    check("f1_valid", 32'(ir_valid), 32'd1);
    check("f1_pc", imem_addr, 32'h4);
    step();
    check("f2_ir", ir, 32'hA5000004);
    check("f2_irpc", ir_pc, 32'h4);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ir", ir, 32'hA5000004);
      check("stall_irpc", ir_pc, 32'h4);
      check("stall_pc", imem_addr, 32'h8);
      check("stall_cnt", fetch_count, 32'd2);
      check("stall_valid", 32'(ir_valid), 32'd1);
    end
    ir_ready = 1'b1;
    step();
    check("f3_ir", ir, 32'hA5000008);
    check("f3_irpc", ir_pc, 32'h8);
    check("f3_cnt", fetch_count, 32'd3);
    step();
`ifdef FETCH_HALT_ON_ZERO_EN
    exp_cnt = 32'd3;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(ir_valid), 32'd0);
    check("halt_pc", imem_addr, 32'hC);
    check("halt_cnt", fetch_count, exp_cnt);
    step();
    check("halt_hold_pc", imem_addr, 32'hC);
    check("halt_hold", 32'(halted), 32'd1);
`else
    exp_cnt = 32'd4;
    check("zero_ir", ir, 32'h0);
    check("zero_valid", 32'(ir_valid), 32'd1);
    check("zero_irpc", ir_pc, 32'hC);
    check("zero_cnt", fetch_count, exp_cnt);
    check("zero_halted", 32'(halted), 32'd0);
`endif
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    check("rd0_valid", 32'(ir_valid), 32'd0);
    check("rd0_pc", imem_addr, 32'h0);
    check("rd0_halted", 32'(halted), 32'd0);
    check("rd0_cnt", fetch_count, exp_cnt);
    check("rd0_mis", 32'(misalign), 32'd0);
    redirect_valid = 1'b0;
    step();
    exp_cnt = exp_cnt + 32'd1;
    check("rd0_ir", ir, 32'hA5000000);
    check("rd0_irpc", ir_pc, 32'h0);
    check("rd0_cnt2", fetch_count, exp_cnt);
    ir_ready = 1'b0;
    step();
    check("st2_ir", ir, 32'hA5000000);
    check("st2_pc", imem_addr, 32'h4);
    redirect_valid = 1'b1; redirect_target = 32'h00000041;
    step();
    check("mis_valid", 32'(ir_valid), 32'd0);
    check("mis_pc", imem_addr, 32'h40);
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_cnt", fetch_count, exp_cnt);
    redirect_valid = 1'b0;
    step();
    exp_cnt = exp_cnt + 32'd1;
    check("mis_irpc", ir_pc, 32'h40);
    check("mis_ir", ir, 32'hA5000040);
    step();
    check("mis_stall_ir", ir, 32'hA5000040);
    check("mis_sticky", 32'(misalign), 32'd1);
    check("mis_stall_cnt", fetch_count, exp_cnt);
    ir_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
    step();
    check("top_pc", imem_addr, 32'hFFFFFFFC);
    redirect_valid = 1'b0;
    step();
    check("top_irpc", ir_pc, 32'hFFFFFFFC);
    check("top_ir", ir, 32'hA5FFFFFC);
    check("wrap_pc", imem_addr, 32'h0);
    step();
    check("wrap_irpc", ir_pc, 32'h0);
    ir_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h80; reset = 1'b1;
    step();
    check("mrst_valid", 32'(ir_valid), 32'd0);
    check("mrst_pc", imem_addr, 32'h0);
    check("mrst_ir", ir, 32'h0);
    check("mrst_irpc", ir_pc, 32'h0);
    check("mrst_cnt", fetch_count, 32'h0);
    check("mrst_mis", 32'(misalign), 32'd0);
    check("mrst_halted", 32'(halted), 32'd0);
    reset = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b1;
    step();
    check("post_ir", ir, 32'hA5000000);
    check("post_cnt", fetch_count, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
